// File: rtl/pipe_seg_adder.sv
// Segmented, pipelined add/subtract unit with valid/ready flow control; one WIDTH/STAGES-bit slice per stage.
// Optional signed-overflow output is enabled by defining PIPE_SEG_ADDER_OVF_EN.
module pipe_seg_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_SEG_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int S     = WIDTH / STAGES;
    localparam int REM_W = (STAGES > 1) ? WIDTH - S : 1;

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] carry_reg;
    logic [WIDTH-1:0]  sum_reg [STAGES];

    // One enable moves the whole pipe, so bubbles are kept and order is preserved.
    assign out_valid = valid_reg[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign b_eff     = sub ? ~b : b;
    assign sum       = sum_reg[STAGES-1];
    assign cout      = carry_reg[STAGES-1];

`ifdef PIPE_SEG_ADDER_OVF_EN
    logic ovf_reg;
    assign ovf = ovf_reg;
`endif

    // Not-yet-consumed operand bits, shifted down one slice per stage so the
    // next slice always sits in the low S bits.
    generate
        if (STAGES > 1) begin : g_ops
            logic [REM_W-1:0] a_rem_reg [STAGES-1];
            logic [REM_W-1:0] b_rem_reg [STAGES-1];

            for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_rem
                logic [REM_W-1:0] a_src;
                logic [REM_W-1:0] b_src;

                if (gi == 0) begin : g_from_port
                    assign a_src = a[WIDTH-1:S];
                    assign b_src = b_eff[WIDTH-1:S];
                end else begin : g_from_prev
                    assign a_src = a_rem_reg[gi-1] >> S;
                    assign b_src = b_rem_reg[gi-1] >> S;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_rem_reg[gi] <= '0;
                        b_rem_reg[gi] <= '0;
                    end else if (adv) begin
                        a_rem_reg[gi] <= a_src;
                        b_rem_reg[gi] <= b_src;
                    end
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [S-1:0]     op_a;
            logic [S-1:0]     op_b;
            logic             carry_in;
            logic             valid_in;
            logic [WIDTH-1:0] sum_prev;
            logic [WIDTH-1:0] sum_next;
            logic [S:0]       slice_sum;

            if (gi == 0) begin : g_head
                // Subtract is a + ~b + 1, so the external carry-in is overridden.
                assign op_a     = a[S-1:0];
                assign op_b     = b_eff[S-1:0];
                assign carry_in = sub | cin;
                assign valid_in = in_valid & in_ready;
                assign sum_prev = '0;
            end else begin : g_body
                assign op_a     = g_ops.a_rem_reg[gi-1][S-1:0];
                assign op_b     = g_ops.b_rem_reg[gi-1][S-1:0];
                assign carry_in = carry_reg[gi-1];
                assign valid_in = valid_reg[gi-1];
                assign sum_prev = sum_reg[gi-1];
            end

            assign slice_sum = {1'b0, op_a} + {1'b0, op_b} + {{S{1'b0}}, carry_in};

            always_comb begin
                sum_next              = sum_prev;
                sum_next[gi*S +: S]   = slice_sum[S-1:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    carry_reg[gi] <= 1'b0;
                    sum_reg[gi]   <= '0;
                end else if (adv) begin
                    valid_reg[gi] <= valid_in;
                    carry_reg[gi] <= slice_sum[S];
                    sum_reg[gi]   <= sum_next;
                end
            end

`ifdef PIPE_SEG_ADDER_OVF_EN
            if (gi == STAGES - 1) begin : g_ovf
                logic msb_carry_in;

                // Carry into the MSB recovered from the MSB's own sum bit.
                assign msb_carry_in = op_a[S-1] ^ op_b[S-1] ^ slice_sum[S-1];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg <= 1'b0;
                    end else if (adv) begin
                        ovf_reg <= msb_carry_in ^ slice_sum[S];
                    end
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Bench for pipe_seg_adder: directed tables, back-pressure, mid-stream reset and
// randomized traffic on 64/4, 8/2 and 16/1 instances against an arithmetic model.
module tb_pipe_seg_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        c;
        logic        v;
    } vec_t;

    // 64-bit, 4 stages
    logic        iv64, ir64, cin64, sub64, ov64, or64, c64;
    logic [63:0] a64, b64, s64;
    // 8-bit, 2 stages
    logic        iv8, ir8, cin8, sub8, ov8, or8, c8;
    logic [7:0]  a8, b8, s8;
    // 16-bit, 1 stage
    logic        iv16, ir16, cin16, sub16, ov16, or16, c16;
    logic [15:0] a16, b16, s16;
`ifdef PIPE_SEG_ADDER_OVF_EN
    logic        f64, f8, f16;
`endif

    pipe_seg_adder #(.WIDTH(64), .STAGES(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .cin(cin64), .sub(sub64),
        .out_valid(ov64), .out_ready(or64), .sum(s64), .cout(c64)
`ifdef PIPE_SEG_ADDER_OVF_EN
        , .ovf(f64)
`endif
    );

    pipe_seg_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(c8)
`ifdef PIPE_SEG_ADDER_OVF_EN
        , .ovf(f8)
`endif
    );

    pipe_seg_adder #(.WIDTH(16), .STAGES(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(c16)
`ifdef PIPE_SEG_ADDER_OVF_EN
        , .ovf(f16)
`endif
    );

    // Plain arithmetic: a+b+cin, or a-b with the borrow mapped to cout=0.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic [64:0] t;
        logic [64:0] m;
        res_t        r;
        m = (65'(1) << w) - 65'(1);
        if (sub) t = {1'b0, a} + (65'(1) << w) - {1'b0, b};
        else     t = {1'b0, a} + {1'b0, b} + 65'(cin);
        r.s = 64'(t & m);
        r.c = t[w];
        if (sub) r.v = (a[w-1] != b[w-1]) && (r.s[w-1] != a[w-1]);
        else     r.v = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    res_t        q64[$];
    res_t        q16[$];
    logic        hold64 = 1'b0, hold16 = 1'b0;
    logic [63:0] held64;
    logic [15:0] held16;
    int          emitted64 = 0;

    // One clock of traffic on the 64-bit unit, entered and left at a falling edge.
    task automatic cycle64(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                           input logic ic, input logic is, input logic ordy, output logic acc);
        res_t e;
        iv64 = iv; a64 = ia; b64 = ib; cin64 = ic; sub64 = is; or64 = ordy;
        #1;
        check("in_ready64", ir64, !ov64 || or64);
        if (hold64) begin
            check("hold64_valid", ov64, 1'b1);
            check("hold64_sum", s64, held64);
        end
        if (ov64 && or64) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat64_extra: got sum %h, expected no beat", s64);
            end else begin
                e = q64.pop_front();
                check("sum64", s64, e.s);
                check("cout64", c64, e.c);
`ifdef PIPE_SEG_ADDER_OVF_EN
                check("ovf64", f64, e.v);
`endif
                emitted64++;
                $display("beat64 sum=%h cout=%b", s64, c64);
            end
        end
        acc = iv && ir64;
        if (acc) q64.push_back(model(64, ia, ib, ic, is));
        hold64 = ov64 && !or64;
        held64 = s64;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle16(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                           input logic ic, input logic is, input logic ordy, output logic acc);
        res_t e;
        iv16 = iv; a16 = ia; b16 = ib; cin16 = ic; sub16 = is; or16 = ordy;
        #1;
        // Single stage: anything accepted is visible right after its accept edge.
        check("occupancy16", ov16, q16.size() != 0);
        check("in_ready16", ir16, !ov16 || or16);
        if (hold16) check("hold16_sum", s16, held16);
        if (ov16 && or16 && q16.size() != 0) begin
            e = q16.pop_front();
            check("sum16", s16, e.s);
            check("cout16", c16, e.c);
`ifdef PIPE_SEG_ADDER_OVF_EN
            check("ovf16", f16, e.v);
`endif
            $display("beat16 sum=%h cout=%b", s16, c16);
        end
        acc = iv && ir16;
        if (acc) q16.push_back(model(16, {48'd0, ia}, {48'd0, ib}, ic, is));
        hold16 = ov16 && !or16;
        held16 = s16;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tab64[8];
    vec_t tab8[7];

    initial begin
        logic acc;
        int   lat, sent, cyc, n_acc, in_i, out_i;

        tab64[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
        tab64[1] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tab64[2] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0};
        tab64[3] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        tab64[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        tab64[5] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 1'b0, 64'h0000_0000_0001_0001, 1'b0, 1'b0};
        tab64[6] = '{64'h55, 64'h55, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
        tab64[7] = '{64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        tab8[0] = '{64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1};
        tab8[1] = '{64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b1};
        tab8[2] = '{64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0};
        tab8[3] = '{64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0};
        tab8[4] = '{64'h80, 64'h80, 1'b0, 1'b0, 64'h00, 1'b1, 1'b1};
        tab8[5] = '{64'h05, 64'h07, 1'b1, 1'b1, 64'hFE, 1'b0, 1'b0};
        tab8[6] = '{64'h7F, 64'h00, 1'b1, 1'b0, 64'h80, 1'b0, 1'b1};

        iv64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; or64 = 1;
        iv8  = 0; a8  = 0; b8  = 0; cin8  = 0; sub8  = 0; or8  = 1;
        iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_valid64", ov64, 1'b0);
        check("reset_sum64", s64, 64'd0);
        check("reset_cout64", c64, 1'b0);
        check("reset_valid8", ov8, 1'b0);
        check("reset_valid16", ov16, 1'b0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready64", ir64, 1'b1);
        check("reset_in_ready16", ir16, 1'b1);
        @(negedge clk);

        // Directed 64-bit vectors with exact latency (edges counted from the accept edge)
        for (int i = 0; i < 8; i++) begin
            iv64 = 1; a64 = tab64[i].a; b64 = tab64[i].b;
            cin64 = tab64[i].cin; sub64 = tab64[i].sub; or64 = 1;
            #1;
            check("tab64_in_ready", ir64, 1'b1);
            @(posedge clk);
            @(negedge clk);
            iv64 = 0;
            lat = 0;
            for (int j = 1; j <= 10 && lat == 0; j++) begin
                if (ov64) lat = j;
                else begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            check("tab64_latency", lat, 4);
            check("tab64_sum", s64, tab64[i].s);
            check("tab64_cout", c64, tab64[i].c);
`ifdef PIPE_SEG_ADDER_OVF_EN
            check("tab64_ovf", f64, tab64[i].v);
`endif
            $display("vec64[%0d] a=%h b=%h sub=%b sum=%h cout=%b lat=%0d",
                     i, tab64[i].a, tab64[i].b, tab64[i].sub, s64, c64, lat);
            @(posedge clk);
            @(negedge clk);
        end

        // Directed 8-bit vectors streamed back to back
        in_i = 0; out_i = 0;
        for (int k = 0; k < 40 && out_i < 7; k++) begin
            iv8 = (in_i < 7);
            if (in_i < 7) begin
                a8 = tab8[in_i].a[7:0]; b8 = tab8[in_i].b[7:0];
                cin8 = tab8[in_i].cin; sub8 = tab8[in_i].sub;
            end
            #1;
            if (ov8) begin
                check("tab8_sum", s8, tab8[out_i].s);
                check("tab8_cout", c8, tab8[out_i].c);
`ifdef PIPE_SEG_ADDER_OVF_EN
                check("tab8_ovf", f8, tab8[out_i].v);
`endif
                $display("vec8[%0d] sum=%h cout=%b", out_i, s8, c8);
                out_i++;
            end
            if (iv8 && ir8) in_i++;
            @(posedge clk);
            @(negedge clk);
        end
        iv8 = 0;
        check("tab8_count", out_i, 7);

        // Back-pressure: out_ready high one cycle in three
        emitted64 = 0; sent = 0; cyc = 0;
        while ((sent < 8 || q64.size() != 0) && cyc < 200) begin
            cycle64(sent < 8, 64'(sent), 64'(sent), 1'b0, 1'b0, (cyc % 3) == 0, acc);
            if (acc) sent++;
            cyc++;
        end
        check("bp_emitted", emitted64, 8);

        // Random 64-bit traffic
        for (int k = 0; k < 300; k++) begin
            cycle64($urandom_range(0, 1) != 0, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 2) != 0, acc);
        end
        for (int k = 0; k < 50 && q64.size() != 0; k++)
            cycle64(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
        check("drain64", q64.size(), 0);

        // Reset mid-stream: three beats in flight, the first stalled at the output
        for (int k = 0; k < 3; k++)
            cycle64(1'b1, 64'(100 + k), 64'd3, 1'b0, 1'b0, 1'b0, acc);
        cycle64(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, acc);
        cycle64(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, acc);
        check("pre_reset_valid", ov64, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", ov64, 1'b0);
        check("midreset_sum", s64, 64'd0);
        check("midreset_cout", c64, 1'b0);
        q64.delete();
        hold64 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postreset_in_ready", ir64, 1'b1);
        for (int k = 0; k < 12; k++)
            cycle64(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);

        // Random 16-bit single-stage traffic
        n_acc = 0; cyc = 0;
        while (n_acc < 1000 && cyc < 5000) begin
            cycle16($urandom_range(0, 1) != 0, 16'($urandom()), 16'($urandom()),
                    $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 3) != 0, acc);
            if (acc) n_acc++;
            cyc++;
        end
        for (int k = 0; k < 10 && q16.size() != 0; k++)
            cycle16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
        check("random16_count", n_acc, 1000);
        check("drain16", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
